// File: rtl/jtlabrun_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jtlabrun_pkg
// Description : Shared slot identifiers and arbiter state encoding for the
//               ROM arbiter and its cache slots.
// Revision    : 1.0 - initial release
// ============================================================================
package jtlabrun_pkg;

    // Requester identifiers, also used as the latched grant id
    localparam logic [1:0] SLOT_CPU = 2'd0;
    localparam logic [1:0] SLOT_SCR = 2'd1;
    localparam logic [1:0] SLOT_OBJ = 2'd2;

    // Arbiter states: at most one SDRAM access in flight at any time
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ACK  = 2'd1,
        WAIT_DATA = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/jtlabrun_rom_slot.sv
`default_nettype none
// ============================================================================
// Module      : jtlabrun_rom_slot
// Description : One-entry read cache for a single ROM client. Holds the tag,
//               valid flag and 32-bit word of the last fetched address and
//               reports hit/miss against the client's current address.
// Revision    : 1.0 - initial release
// ============================================================================
module jtlabrun_rom_slot #(
    parameter int TAG_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cs,
    input  logic [TAG_W-1:0] tag,
    input  logic             wr,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [31:0]      wr_data,
    output logic             hit,
    output logic             miss,
    output logic [31:0]      data
);

    logic             r_valid;
    logic [TAG_W-1:0] r_tag;
    logic [31:0]      r_data;

    // Cache entry update on a completed SDRAM read for this slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_tag   <= '0;
            r_data  <= '0;
        end else if (wr) begin
            r_valid <= 1'b1;
            r_tag   <= wr_tag;
            r_data  <= wr_data;
        end
    end

    // A dropped cs forces both hit and miss low
    assign hit  = cs & r_valid & (r_tag == tag);
    assign miss = cs & ~hit;
    assign data = r_data;

endmodule
`default_nettype wire

// File: rtl/jtlabrun_rom_arb.sv
`default_nettype none
// ============================================================================
// Module      : jtlabrun_rom_arb
// Description : Shares the SDRAM read port between the CPU program ROM and the
//               scroll/object graphics ROMs. CPU has fixed priority; scroll
//               and object alternate. Each client has a one-entry cache.
// Revision    : 1.0 - initial release
// ============================================================================
module jtlabrun_rom_arb
    import jtlabrun_pkg::*;
#(
    parameter int                  CPU_AW     = 17,
    parameter int                  GFX_AW     = 18,
    parameter int                  SDRAM_AW   = 22,
    parameter logic [SDRAM_AW-1:0] CPU_OFFSET = 22'h00000,
    parameter logic [SDRAM_AW-1:0] SCR_OFFSET = 22'h10000,
    parameter logic [SDRAM_AW-1:0] OBJ_OFFSET = 22'h90000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CPU_AW-1:0]   cpu_addr,
    input  logic                cpu_cs,
    output logic                cpu_ok,
    output logic [7:0]          cpu_data,
    input  logic [GFX_AW-1:0]   scr_addr,
    input  logic                scr_cs,
    output logic                scr_ok,
    output logic [31:0]         scr_data,
    input  logic [GFX_AW-1:0]   obj_addr,
    input  logic                obj_cs,
    output logic                obj_ok,
    output logic [31:0]         obj_data,
    output logic [SDRAM_AW-1:0] sdram_addr,
    output logic                sdram_req,
    input  logic                sdram_ack,
    input  logic                data_rdy,
    input  logic [31:0]         data_read
);

    localparam int CPU_TW = CPU_AW - 2;
    // Latched tag must fit the widest client tag
    localparam int LT_W   = (GFX_AW > CPU_TW) ? GFX_AW : CPU_TW;

    arb_state_t          r_state;
    arb_state_t          w_state_nx;
    logic [1:0]          r_slot;
    logic [LT_W-1:0]     r_tag;
    logic [SDRAM_AW-1:0] r_addr;
    logic                r_ptr_obj;

    logic [CPU_TW-1:0]   w_cpu_tag;
    logic [SDRAM_AW-1:0] w_cpu_sd, w_scr_sd, w_obj_sd;
    logic                w_cpu_miss, w_scr_miss, w_obj_miss;
    logic [31:0]         w_cpu_word;
    logic                w_gnt_valid;
    logic [1:0]          w_gnt_slot;
    logic [SDRAM_AW-1:0] w_gnt_addr;
    logic [LT_W-1:0]     w_gnt_tag;
    logic                w_grant;
    logic                w_cache_wr;

    assign w_cpu_tag = cpu_addr[CPU_AW-1:2];

    // 16-bit SDRAM word addresses: each 32-bit ROM word spans two SDRAM words
    assign w_cpu_sd = CPU_OFFSET + SDRAM_AW'({w_cpu_tag, 1'b0});
    assign w_scr_sd = SCR_OFFSET + SDRAM_AW'({scr_addr, 1'b0});
    assign w_obj_sd = OBJ_OFFSET + SDRAM_AW'({obj_addr, 1'b0});

    jtlabrun_rom_slot #(.TAG_W(CPU_TW)) u_cpu_slot (
        .clk     (clk),
        .rst     (rst),
        .cs      (cpu_cs),
        .tag     (w_cpu_tag),
        .wr      (w_cache_wr && (r_slot == SLOT_CPU)),
        .wr_tag  (r_tag[CPU_TW-1:0]),
        .wr_data (data_read),
        .hit     (cpu_ok),
        .miss    (w_cpu_miss),
        .data    (w_cpu_word)
    );

    jtlabrun_rom_slot #(.TAG_W(GFX_AW)) u_scr_slot (
        .clk     (clk),
        .rst     (rst),
        .cs      (scr_cs),
        .tag     (scr_addr),
        .wr      (w_cache_wr && (r_slot == SLOT_SCR)),
        .wr_tag  (r_tag[GFX_AW-1:0]),
        .wr_data (data_read),
        .hit     (scr_ok),
        .miss    (w_scr_miss),
        .data    (scr_data)
    );

    jtlabrun_rom_slot #(.TAG_W(GFX_AW)) u_obj_slot (
        .clk     (clk),
        .rst     (rst),
        .cs      (obj_cs),
        .tag     (obj_addr),
        .wr      (w_cache_wr && (r_slot == SLOT_OBJ)),
        .wr_tag  (r_tag[GFX_AW-1:0]),
        .wr_data (data_read),
        .hit     (obj_ok),
        .miss    (w_obj_miss),
        .data    (obj_data)
    );

    // Byte lane select for the CPU from the cached word
    always_comb begin
        cpu_data = w_cpu_word[7:0];
        case (cpu_addr[1:0])
            2'd1:    cpu_data = w_cpu_word[15:8];
            2'd2:    cpu_data = w_cpu_word[23:16];
            2'd3:    cpu_data = w_cpu_word[31:24];
            default: cpu_data = w_cpu_word[7:0];
        endcase
    end

    // Winner selection: CPU first, then the graphics slot the pointer favours
    always_comb begin
        w_gnt_valid = 1'b1;
        w_gnt_slot  = SLOT_CPU;
        w_gnt_addr  = w_cpu_sd;
        w_gnt_tag   = LT_W'(w_cpu_tag);
        if (w_cpu_miss) begin
            w_gnt_slot = SLOT_CPU;
        end else if (w_scr_miss && (!w_obj_miss || !r_ptr_obj)) begin
            w_gnt_slot = SLOT_SCR;
            w_gnt_addr = w_scr_sd;
            w_gnt_tag  = LT_W'(scr_addr);
        end else if (w_obj_miss) begin
            w_gnt_slot = SLOT_OBJ;
            w_gnt_addr = w_obj_sd;
            w_gnt_tag  = LT_W'(obj_addr);
        end else begin
            w_gnt_valid = 1'b0;
        end
    end

    // Arbiter state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next state, grant and cache-write strobes
    always_comb begin
        w_state_nx = r_state;
        w_grant    = 1'b0;
        w_cache_wr = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_gnt_valid) begin
                    w_grant    = 1'b1;
                    w_state_nx = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (sdram_ack) begin
                    if (data_rdy) begin
                        w_cache_wr = 1'b1;
                        w_state_nx = IDLE;
                    end else begin
                        w_state_nx = WAIT_DATA;
                    end
                end
            end
            WAIT_DATA: begin
                if (data_rdy) begin
                    w_cache_wr = 1'b1;
                    w_state_nx = IDLE;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    // Latch the granted request and advance the graphics round-robin pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slot    <= SLOT_CPU;
            r_tag     <= '0;
            r_addr    <= '0;
            r_ptr_obj <= 1'b0;
        end else if (w_grant) begin
            r_slot <= w_gnt_slot;
            r_tag  <= w_gnt_tag;
            r_addr <= w_gnt_addr;
            if (w_gnt_slot != SLOT_CPU) begin
                r_ptr_obj <= (w_gnt_slot == SLOT_SCR);
            end
        end
    end

    assign sdram_req  = (r_state == WAIT_ACK);
    assign sdram_addr = r_addr;

endmodule
`default_nettype wire
